tim_gp: RTL and testbench

General-purpose timer with parametrised counter width and compare-channel count. Provides:
- a prescaler;
- up, down and center-aligned counting;
- auto-reload with optional preload (shadow) registers;
- one-pulse mode;
- per-channel PWM outputs and compare flags;
- sticky interrupt flags with a combined irq line.

It sits on the peripheral side of the core. Configuration inputs are driven by the timer register file, and irq is routed to the interrupt controller.

---
 rtl/tim_pkg.sv | 25 ++
 rtl/tim_prescaler.sv | 45 ++++
 rtl/tim_gp.sv | 154 +++++++++++++++
 tb/tb_tim_gp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tim_pkg.sv
// rtl/tim_pkg.sv - shared types and default widths for the general-purpose timer
// Purpose: counting-mode enum, default parameter values and the mode decoder
//          used by tim_gp.
package tim_pkg;

  typedef enum logic [1:0] {
    TIM_UP     = 2'b00,
    TIM_DOWN   = 2'b01,
    TIM_CENTER = 2'b10
  } tim_mode_e;

  localparam int TIM_CNT_W_DEF  = 16;
  localparam int TIM_PSC_W_DEF  = 16;
  localparam int TIM_NUM_CH_DEF = 2;

  // Encoding 2'b11 is reserved and behaves as edge-up.
  function automatic tim_mode_e tim_decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return TIM_DOWN;
      2'b10:   return TIM_CENTER;
      default: return TIM_UP;
    endcase
  endfunction

endpackage

// File: rtl/tim_prescaler.sv
// rtl/tim_prescaler.sv - clock prescaler producing the counter tick
// Purpose: divides clk by (psc_sh+1) while running; psc_sh is the shadowed
//          prescaler value, reloaded whenever load is high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         prescaler advances only when high
//   ug          software update: restarts the division from zero, suppresses tick
//   load        copy psc into the shadow at this edge (update event or ug)
//   psc         prescaler value from the register file
//   tick        single-cycle count-enable for the counter
module tim_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             ug,
  input  logic             load,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] psc_sh;
  logic             wrap;

  assign wrap = (psc_cnt == psc_sh);
  // ug wins over a coincident tick so the counter only sees the update.
  assign tick = run & ~ug & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
      psc_sh  <= '0;
    end else begin
      if (load) psc_sh <= psc;
      if (ug) begin
        psc_cnt <= '0;
      end else if (run) begin
        psc_cnt <= wrap ? '0 : psc_cnt + PSC_W'(1);
      end
    end
  end

endmodule

// File: rtl/tim_gp.sv
// rtl/tim_gp.sv - general-purpose timer: up/down/center counting, PWM compare, irq
// Purpose: prescaled counter with auto-reload (optionally shadowed), one-pulse
//          mode, NUM_CH PWM-mode-1 compare channels and sticky interrupt flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en, mode, opm     enable, counting mode, one-pulse mode
//   arpe, psc, arr    ARR preload enable, prescaler, auto-reload
//   ccr               compare values, channel i at [i*CNT_W +: CNT_W]
//   ug                software update pulse
//   uie, ccie         interrupt enables
//   uif_clr, ccif_clr flag clears
//   cnt, dir_o        counter value and direction (1 = down)
//   ch_out            PWM outputs (high while cnt < ccr)
//   uif, ccif, irq    sticky flags and combined interrupt
module tim_gp
  import tim_pkg::*;
#(
  parameter int CNT_W  = TIM_CNT_W_DEF,
  parameter int PSC_W  = TIM_PSC_W_DEF,
  parameter int NUM_CH = TIM_NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    opm,
  input  logic                    arpe,
  input  logic [PSC_W-1:0]        psc,
  input  logic [CNT_W-1:0]        arr,
  input  logic [NUM_CH*CNT_W-1:0] ccr,
  input  logic                    ug,
  input  logic                    uie,
  input  logic [NUM_CH-1:0]       ccie,
  input  logic                    uif_clr,
  input  logic [NUM_CH-1:0]       ccif_clr,
  output logic [CNT_W-1:0]        cnt,
  output logic                    dir_o,
  output logic [NUM_CH-1:0]       ch_out,
  output logic                    uif,
  output logic [NUM_CH-1:0]       ccif,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  tim_mode_e        mode_d;
  logic             run, tick, uev, load, cnt_wr, opm_done, dir_nxt;
  logic [CNT_W-1:0] arr_sh, arr_act, cnt_nxt;
  logic [CNT_W-1:0] ccr_sh [NUM_CH];

  assign mode_d  = tim_decode_mode(mode);
  assign run     = en & ~opm_done;
  assign arr_act = arpe ? arr_sh : arr;
  assign load    = ug | uev;
  assign cnt_wr  = ug | tick;
  assign irq     = (uif & uie) | (|(ccif & ccie));

  tim_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .ug   (ug),
    .load (load),
    .psc  (psc),
    .tick (tick)
  );

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_o;
    uev     = 1'b0;
    if (ug) begin
      // ug reloads from the raw arr input, which is also what the shadow takes.
      cnt_nxt = (mode_d == TIM_DOWN) ? arr : '0;
      dir_nxt = (mode_d == TIM_DOWN);
    end else if (tick) begin
      if (arr_act == '0) begin
        cnt_nxt = '0;
        uev     = 1'b1;
        if (mode_d != TIM_CENTER) dir_nxt = (mode_d == TIM_DOWN);
      end else begin
        case (mode_d)
          TIM_DOWN: begin
            dir_nxt = 1'b1;
            if (cnt == '0) begin
              cnt_nxt = arr_act;
              uev     = 1'b1;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
          TIM_CENTER: begin
            if (!dir_o) begin
              if (cnt == arr_act) begin
                cnt_nxt = arr_act - ONE;
                dir_nxt = 1'b1;
                uev     = 1'b1;
              end else begin
                cnt_nxt = cnt + ONE;
              end
            end else if (cnt == '0) begin
              cnt_nxt = ONE;
              dir_nxt = 1'b0;
              uev     = 1'b1;
            end else begin
              cnt_nxt = cnt - ONE;
            end
          end
          default: begin
            // cnt above a lowered ARR runs on and wraps through all-ones.
            dir_nxt = 1'b0;
            if (cnt == arr_act) begin
              cnt_nxt = '0;
              uev     = 1'b1;
            end else begin
              cnt_nxt = cnt + ONE;
            end
          end
        endcase
      end
      // One-pulse in center mode parks at 0 rather than turning around.
      if (uev && opm && mode_d == TIM_CENTER) begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_o    <= 1'b0;
      uif      <= 1'b0;
      ccif     <= '0;
      ch_out   <= '0;
      opm_done <= 1'b0;
      arr_sh   <= '1;
      for (int i = 0; i < NUM_CH; i++) ccr_sh[i] <= '0;
    end else begin
      cnt   <= cnt_nxt;
      dir_o <= dir_nxt;
      uif   <= (uif & ~uif_clr) | load;
      if (load) arr_sh <= arr;
      for (int i = 0; i < NUM_CH; i++) begin
        ccif[i]   <= (ccif[i] & ~ccif_clr[i]) | (cnt_wr && (cnt_nxt == ccr_sh[i]));
        ch_out[i] <= (cnt_nxt < ccr_sh[i]);
        if (load) ccr_sh[i] <= ccr[i*CNT_W +: CNT_W];
      end
      if (!en) opm_done <= 1'b0;
      else if (uev && opm) opm_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tim_gp.sv
// tb/tb_tim_gp.sv - self-checking bench for tim_gp
// Purpose: table-driven counting/PWM vectors plus directed multi-cycle sequences.
module tb_tim_gp;

  localparam int CNT_W  = 8;
  localparam int PSC_W  = 8;
  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              rst_n, en, opm, arpe, ug, uie, uif_clr;
  logic [1:0]        mode;
  logic [PSC_W-1:0]  psc;
  logic [CNT_W-1:0]  arr;
  logic [2*CNT_W-1:0] ccr;
  logic [1:0]        ccie, ccif_clr;
  logic [CNT_W-1:0]  cnt;
  logic              dir_o, uif, irq;
  logic [1:0]        ch_out, ccif;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tim_gp #(.CNT_W(CNT_W), .PSC_W(PSC_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .opm(opm), .arpe(arpe),
    .psc(psc), .arr(arr), .ccr(ccr), .ug(ug), .uie(uie), .ccie(ccie),
    .uif_clr(uif_clr), .ccif_clr(ccif_clr), .cnt(cnt), .dir_o(dir_o),
    .ch_out(ch_out), .uif(uif), .ccif(ccif), .irq(irq)
  );

  typedef struct {
    logic [1:0]      mode;
    logic [7:0]      psc;
    logic [7:0]      arr;
    logic [7:0]      ccr0;
    logic [7:0]      init;
    logic [0:7][7:0] seq;
    logic [0:7]      dir_exp;
    logic [0:7]      ch_exp;
    logic            ccif_exp;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse ug with the counter stopped, then clear all flags for one cycle.
  task automatic update_and_clear();
    en = 1'b0;
    ug = 1'b1;
    step();
    ug       = 1'b0;
    uif_clr  = 1'b1;
    ccif_clr = 2'b11;
    step();
    uif_clr  = 1'b0;
    ccif_clr = 2'b00;
  endtask

  initial begin
    vt[0] = '{2'b00, 8'd1, 8'd4, 8'd2, 8'd0, {8'd1,8'd2,8'd3,8'd4,8'd0,8'd1,8'd2,8'd3}, 8'b00000000, 8'b10001100, 1'b1};
    vt[1] = '{2'b00, 8'd0, 8'd4, 8'd0, 8'd0, {8'd1,8'd2,8'd3,8'd4,8'd0,8'd1,8'd2,8'd3}, 8'b00000000, 8'b00000000, 1'b1};
    vt[2] = '{2'b00, 8'd0, 8'd4, 8'd5, 8'd0, {8'd1,8'd2,8'd3,8'd4,8'd0,8'd1,8'd2,8'd3}, 8'b00000000, 8'b11111111, 1'b0};
    vt[3] = '{2'b10, 8'd0, 8'd3, 8'd2, 8'd0, {8'd1,8'd2,8'd3,8'd2,8'd1,8'd0,8'd1,8'd2}, 8'b00011100, 8'b10001110, 1'b1};
    vt[4] = '{2'b01, 8'd0, 8'd3, 8'd2, 8'd3, {8'd2,8'd1,8'd0,8'd3,8'd2,8'd1,8'd0,8'd3}, 8'b11111111, 8'b01100110, 1'b1};
    vt[5] = '{2'b11, 8'd2, 8'd2, 8'd1, 8'd0, {8'd1,8'd2,8'd0,8'd1,8'd2,8'd0,8'd1,8'd2}, 8'b00000000, 8'b00100100, 1'b1};

    rst_n = 1'b0; en = 1'b0; opm = 1'b0; arpe = 1'b0; ug = 1'b0; uie = 1'b0;
    uif_clr = 1'b0; mode = 2'b00; psc = '0; arr = '0; ccr = '0; ccie = '0; ccif_clr = '0;
    #12;
    chk("reset cnt", cnt, 0);
    chk("reset dir", dir_o, 0);
    chk("reset ch_out", ch_out, 0);
    chk("reset uif", uif, 0);
    chk("reset ccif", ccif, 0);
    chk("reset irq", irq, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      mode = vt[i].mode;
      psc  = vt[i].psc;
      arr  = vt[i].arr;
      ccr  = {8'hFF, vt[i].ccr0};
      update_and_clear();
      chk($sformatf("v%0d init cnt", i), cnt, vt[i].init);
      chk($sformatf("v%0d init uif", i), uif, 0);
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
        repeat (int'(vt[i].psc) + 1) step();
        chk($sformatf("v%0d cnt[%0d]", i, k), cnt, vt[i].seq[k]);
        chk($sformatf("v%0d dir[%0d]", i, k), dir_o, vt[i].dir_exp[k]);
        chk($sformatf("v%0d ch0[%0d]", i, k), ch_out[0], vt[i].ch_exp[k]);
      end
      chk($sformatf("v%0d uif", i), uif, 1);
      chk($sformatf("v%0d ccif0", i), ccif[0], vt[i].ccif_exp);
    end
    en = 1'b0;

    // irq gating: uif=1, ccif=01 left over from the last vector
    chk("irq none", irq, 0);
    uie = 1'b1; #1;
    chk("irq uie", irq, 1);
    uie = 1'b0; ccie = 2'b01; #1;
    chk("irq ccie0", irq, 1);
    ccie = 2'b10; #1;
    chk("irq ccie1", irq, 0);
    ccie = 2'b00;

    // ARR preloaded: change at cnt=6 only takes effect after the 9->0 update
    mode = 2'b00; psc = 8'd0; arr = 8'd9; ccr = {8'hFF, 8'd2}; arpe = 1'b1;
    update_and_clear();
    en = 1'b1;
    repeat (6) step();
    chk("arpe1 cnt6", cnt, 6);
    arr = 8'd4;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] e;
      e = (k < 3) ? 8'(7 + k) : 8'((k - 3) % 5);
      step();
      chk($sformatf("arpe1 cnt[%0d]", k), cnt, e);
    end

    // ARR direct: lowered below cnt, counter runs through all-ones
    arr = 8'd9; arpe = 1'b0;
    update_and_clear();
    en = 1'b1;
    repeat (6) step();
    arr = 8'd4;
    repeat (249) step();
    chk("arpe0 cnt255", cnt, 255);
    chk("arpe0 no uev", uif, 0);
    step();
    chk("arpe0 wrap0", cnt, 0);
    chk("arpe0 wrap no uev", uif, 0);
    repeat (4) step();
    chk("arpe0 cnt4", cnt, 4);
    step();
    chk("arpe0 reload", cnt, 0);
    chk("arpe0 uif", uif, 1);

    // One-pulse mode
    arr = 8'd3; opm = 1'b1;
    update_and_clear();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'((k + 1) % 4);
      step();
      chk($sformatf("opm cnt[%0d]", k), cnt, e);
    end
    repeat (3) step();
    chk("opm hold", cnt, 0);
    chk("opm uif", uif, 1);
    en = 1'b0; step();
    en = 1'b1; step();
    chk("opm restart", cnt, 1);
    repeat (3) step();
    chk("opm second end", cnt, 0);
    step();
    chk("opm second hold", cnt, 0);
    opm = 1'b0;

    // Set and clear in the same cycle: set wins
    update_and_clear();
    en = 1'b1;
    repeat (3) step();
    chk("coin cnt3", cnt, 3);
    uif_clr = 1'b1;
    step();
    chk("coin uif set wins", uif, 1);
    ccif_clr = 2'b01;
    step();
    chk("coin uif cleared", uif, 0);
    chk("coin ccif cleared", ccif[0], 0);
    step();
    chk("coin ccif set wins", ccif[0], 1);
    uif_clr = 1'b0; ccif_clr = 2'b00;

    // Freeze with en low
    en = 1'b0;
    repeat (5) step();
    chk("freeze cnt", cnt, 2);
    en = 1'b1;
    step();
    chk("resume cnt", cnt, 3);

    // Asynchronous reset between edges
    step();
    step();
    chk("pre-reset cnt", cnt, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async cnt", cnt, 0);
    chk("async uif", uif, 0);
    chk("async ccif", ccif, 0);
    chk("async ch_out", ch_out, 0);
    chk("async dir", dir_o, 0);
    chk("async irq", irq, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post-reset cnt", cnt, 1);
    chk("post-reset ch_out", ch_out[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
